// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// Writeback stage and architectural register file for the miniRV pipeline.
// It takes the MEM/WB pipeline register outputs, picks the writeback value,
// commits that value to the 32x32 register file, and serves the two ID-stage
// read ports. A same-cycle bypass forwards a commit to the read ports, which
// closes the WB->ID hazard. Registered trace outputs and a commit counter
// feed the debug and trace-checker logic.
//
// Parameters:
//   X2_RESET    reset value of x2 (sp); every other register resets to 0
//   CNT_W       width of the commit counter
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   wb_rf_we    writeback enable from MEM/WB
//   wb_rf_wsel  writeback source select (00 ALU, 01 load, 10 pc+4, 11 imm)
//   wb_wR       destination register index
//   wb_ALU_C    ALU result
//   wb_DRAM_rdo load data
//   wb_pc4      PC+4 link value
//   wb_imm_ext  extended immediate (lui)
//   rR1, rR2    ID-stage read indices
//   rD1, rD2    read data (combinational, with same-cycle bypass)
//   wb_wD       selected writeback value (combinational)
//   dbg_we      registered: a commit occurred last cycle
//   dbg_wR      registered: last committed register index
//   dbg_wD      registered: last committed value
//   commit_cnt  number of commits since reset (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter logic [31:0] X2_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_rf_we,
    input  logic [1:0]       wb_rf_wsel,
    input  logic [4:0]       wb_wR,
    input  logic [31:0]      wb_ALU_C,
    input  logic [31:0]      wb_DRAM_rdo,
    input  logic [31:0]      wb_pc4,
    input  logic [31:0]      wb_imm_ext,
    input  logic [4:0]       rR1,
    input  logic [4:0]       rR2,
    output logic [31:0]      rD1,
    output logic [31:0]      rD2,
    output logic [31:0]      wb_wD,
    output logic             dbg_we,
    output logic [4:0]       dbg_wR,
    output logic [31:0]      dbg_wD,
    output logic [CNT_W-1:0] commit_cnt
);

    // x0 is hardwired to zero, so it has no storage.
    logic [31:0]      regs_q [1:31];
    logic [31:0]      regs_d [1:31];

    logic             commit;
    logic             dbg_we_q,  dbg_we_d;
    logic [4:0]       dbg_wR_q,  dbg_wR_d;
    logic [31:0]      dbg_wD_q,  dbg_wD_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // Writeback source mux. It is driven whether or not a write is enabled.
    always_comb begin
        wb_wD = wb_ALU_C;
        unique case (wb_rf_wsel)
            2'b00:   wb_wD = wb_ALU_C;
            2'b01:   wb_wD = wb_DRAM_rdo;
            2'b10:   wb_wD = wb_pc4;
            default: wb_wD = wb_imm_ext;
        endcase
    end

    // A write to x0 is not a commit. A commit is also suppressed while reset
    // is held. This keeps the bypass from leaking an incoming value onto the
    // read ports while they must show the reset contents.
    assign commit = wb_rf_we && (wb_wR != 5'd0) && !rst;

    // One register per entry. Each entry has its own async reset value, so
    // the file is built from flops rather than a RAM.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            localparam logic [31:0] RST_VAL = (gi == 2) ? X2_RESET : 32'h0;

            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (commit && (wb_wR == 5'(gi))) begin
                    regs_d[gi] = wb_wD;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_q[gi] <= RST_VAL;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    // Read ports. The bypass has priority over the array so that a consumer
    // in ID sees the value being committed this cycle.
    always_comb begin
        rD1 = 32'h0;
        if (rR1 != 5'd0) begin
            rD1 = (commit && (rR1 == wb_wR)) ? wb_wD : regs_q[rR1];
        end
    end

    always_comb begin
        rD2 = 32'h0;
        if (rR2 != 5'd0) begin
            rD2 = (commit && (rR2 == wb_wR)) ? wb_wD : regs_q[rR2];
        end
    end

    // Trace and counter next-state. The index and data hold between commits
    // so that the trace checker always sees the most recent commit.
    always_comb begin
        dbg_we_d = commit;
        dbg_wR_d = dbg_wR_q;
        dbg_wD_d = dbg_wD_q;
        cnt_d    = cnt_q;
        if (commit) begin
            dbg_wR_d = wb_wR;
            dbg_wD_d = wb_wD;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_we_q <= 1'b0;
            dbg_wR_q <= 5'd0;
            dbg_wD_q <= 32'h0;
            cnt_q    <= '0;
        end else begin
            dbg_we_q <= dbg_we_d;
            dbg_wR_q <= dbg_wR_d;
            dbg_wD_q <= dbg_wD_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dbg_we     = dbg_we_q;
    assign dbg_wR     = dbg_wR_q;
    assign dbg_wD     = dbg_wD_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//
// Directed testbench for wb_regfile. The DUT is built with X2_RESET=32'h7FFC
// and CNT_W=4 so that counter wrap is reachable in a short run. Inputs change
// 1 time unit after a rising edge. Every check is made between edges.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_rf_we;
    logic [1:0]       wb_rf_wsel;
    logic [4:0]       wb_wR;
    logic [31:0]      wb_ALU_C;
    logic [31:0]      wb_DRAM_rdo;
    logic [31:0]      wb_pc4;
    logic [31:0]      wb_imm_ext;
    logic [4:0]       rR1;
    logic [4:0]       rR2;
    logic [31:0]      rD1;
    logic [31:0]      rD2;
    logic [31:0]      wb_wD;
    logic             dbg_we;
    logic [4:0]       dbg_wR;
    logic [31:0]      dbg_wD;
    logic [CNT_W-1:0] commit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile #(
        .X2_RESET (32'h0000_7FFC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_rf_we    (wb_rf_we),
        .wb_rf_wsel  (wb_rf_wsel),
        .wb_wR       (wb_wR),
        .wb_ALU_C    (wb_ALU_C),
        .wb_DRAM_rdo (wb_DRAM_rdo),
        .wb_pc4      (wb_pc4),
        .wb_imm_ext  (wb_imm_ext),
        .rR1         (rR1),
        .rR2         (rR2),
        .rD1         (rD1),
        .rD2         (rD2),
        .wb_wD       (wb_wD),
        .dbg_we      (dbg_we),
        .dbg_wR      (dbg_wR),
        .dbg_wD      (dbg_wD),
        .commit_cnt  (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_commit(input logic we, input logic [4:0] wr,
                                input logic [1:0] wsel, input logic [31:0] alu);
        wb_rf_we   = we;
        wb_wR      = wr;
        wb_rf_wsel = wsel;
        wb_ALU_C   = alu;
    endtask

    initial begin
        logic [31:0] src_exp [4];
        src_exp[0] = 32'h11; src_exp[1] = 32'h22;
        src_exp[2] = 32'h33; src_exp[3] = 32'h44;

        rst         = 1'b1;
        wb_rf_we    = 1'b0;
        wb_rf_wsel  = 2'b00;
        wb_wR       = 5'd0;
        wb_ALU_C    = 32'h11;
        wb_DRAM_rdo = 32'h22;
        wb_pc4      = 32'h33;
        wb_imm_ext  = 32'h44;
        rR1         = 5'd2;
        rR2         = 5'd5;

        // ---- Reset state. A commit presented during reset is discarded.
        tick();
        drive_commit(1'b1, 5'd5, 2'b00, 32'h55);
        #1;
        check_eq("rst_x2",    rD1, 32'h0000_7FFC);
        check_eq("rst_x5",    rD2, 32'h0);
        check_eq("rst_cnt",   32'(commit_cnt), 32'h0);
        check_eq("rst_dbgwe", 32'(dbg_we), 32'h0);
        tick();
        drive_commit(1'b0, 5'd0, 2'b00, 32'h11);
        #3 rst = 1'b0;               // release mid-cycle
        tick();
        check_eq("rst_x5_after", rD2, 32'h0);
        check_eq("rst_cnt_after", 32'(commit_cnt), 32'h0);

        // ---- Source select: commit to x5 from each of the four sources.
        rR1 = 5'd5;
        rR2 = 5'd5;
        for (int i = 0; i < 4; i++) begin
            drive_commit(1'b1, 5'd5, 2'(i), 32'h11);
            #1;
            check_eq($sformatf("wsel%0d_wD", i), wb_wD, src_exp[i]);
            tick();
            wb_rf_we = 1'b0;
            #1;
            check_eq($sformatf("wsel%0d_x5", i), rD1, src_exp[i]);
        end
        check_eq("sel_cnt",   32'(commit_cnt), 32'd4);
        check_eq("sel_dbgwr", 32'(dbg_wR), 32'd5);
        check_eq("sel_dbgwd", dbg_wD, 32'h44);

        // ---- Bypass: both ports see x7 in the same cycle it is presented.
        rR1 = 5'd7;
        rR2 = 5'd7;
        drive_commit(1'b1, 5'd7, 2'b00, 32'hDEAD_BEEF);
        #1;
        check_eq("byp_rD1", rD1, 32'hDEAD_BEEF);
        check_eq("byp_rD2", rD2, 32'hDEAD_BEEF);
        tick();
        wb_rf_we = 1'b0;
        wb_ALU_C = 32'h0;
        #1;
        check_eq("arr_rD1",   rD1, 32'hDEAD_BEEF);
        check_eq("arr_rD2",   rD2, 32'hDEAD_BEEF);
        check_eq("byp_dbgwe", 32'(dbg_we), 32'h1);
        check_eq("byp_dbgwd", dbg_wD, 32'hDEAD_BEEF);
        check_eq("byp_cnt",   32'(commit_cnt), 32'd5);

        // ---- A write to x0 is not a commit.
        rR1 = 5'd0;
        drive_commit(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF);
        #1;
        check_eq("x0_wD",  wb_wD, 32'hFFFF_FFFF);
        check_eq("x0_rD1", rD1, 32'h0);
        tick();
        wb_rf_we = 1'b0;
        #1;
        check_eq("x0_dbgwe",  32'(dbg_we), 32'h0);
        check_eq("x0_cnt",    32'(commit_cnt), 32'd5);
        check_eq("x0_dbgwd_hold", dbg_wD, 32'hDEAD_BEEF);
        check_eq("x0_rD1_after",  rD1, 32'h0);

        // ---- Mid-cycle reset pulse, then 17 commits to wrap the 4-bit counter.
        #2 rst = 1'b1;
        #1;
        check_eq("pulse_cnt", 32'(commit_cnt), 32'h0);
        #1 rst = 1'b0;
        rR1 = 5'd7;
        rR2 = 5'd2;
        #1;
        check_eq("pulse_x7", rD1, 32'h0);
        check_eq("pulse_x2", rD2, 32'h0000_7FFC);
        tick();
        for (int i = 1; i <= 17; i++) begin
            drive_commit(1'b1, 5'(i), 2'b00, 32'hA000_0000 + i);
            tick();
            check_eq($sformatf("trc%0d_we", i), 32'(dbg_we), 32'h1);
            check_eq($sformatf("trc%0d_wR", i), 32'(dbg_wR), i);
            check_eq($sformatf("trc%0d_wD", i), dbg_wD, 32'hA000_0000 + i);
        end
        wb_rf_we = 1'b0;
        rR1 = 5'd1;
        rR2 = 5'd17;
        #1;
        check_eq("wrap_cnt", 32'(commit_cnt), 32'd1);
        check_eq("wrap_x1",  rD1, 32'hA000_0001);
        check_eq("wrap_x17", rD2, 32'hA000_0011);

        // ---- Back-to-back commits to x3: the last writer wins.
        rR1 = 5'd3;
        drive_commit(1'b1, 5'd3, 2'b00, 32'h111);
        tick();
        drive_commit(1'b1, 5'd3, 2'b00, 32'h222);
        #1;
        check_eq("b2b_byp", rD1, 32'h222);
        tick();
        check_eq("b2b_trc1", dbg_wD, 32'h222);
        wb_rf_we = 1'b0;
        #1;
        check_eq("b2b_x3",  rD1, 32'h222);
        check_eq("b2b_cnt", 32'(commit_cnt), 32'd3);

        // ---- Reset while a commit to x9 is presented.
        rR1 = 5'd9;
        rR2 = 5'd2;
        drive_commit(1'b1, 5'd9, 2'b00, 32'h1234);
        #2 rst = 1'b1;
        #1;
        check_eq("rstmid_rD1", rD1, 32'h0);
        tick();
        #3 rst = 1'b0;
        wb_rf_we = 1'b0;
        tick();
        check_eq("rstmid_x9",    rD1, 32'h0);
        check_eq("rstmid_x2",    rD2, 32'h0000_7FFC);
        check_eq("rstmid_cnt",   32'(commit_cnt), 32'h0);
        check_eq("rstmid_dbgwe", 32'(dbg_we), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file of the miniRV five-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value, commits it to the 32×32 register file, and serves the two ID-stage read ports. Same-cycle write-to-read bypass closes the WB→ID hazard. Registered commit-trace outputs and a commit counter support debug and the trace checker.

## Interface
Parameters:
- X2_RESET, 32'h0000_0000, reset value of x2 (sp); all other registers reset to 0
- CNT_W, 32, width of commit counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_rf_we  in  1  writeback enable from MEM/WB
- wb_rf_wsel  in  2  writeback source select
- wb_wR  in  5  destination register index
- wb_ALU_C  in  32  ALU result
- wb_DRAM_rdo  in  32  load data
- wb_pc4  in  32  PC+4 (link value)
- wb_imm_ext  in  32  extended immediate (lui)
- rR1, rR2  in  5  ID-stage read indices
- rD1, rD2  out  32  read data (combinational)
- wb_wD  out  32  selected writeback value (combinational)
- dbg_we  out  1  registered: a commit occurred last cycle
- dbg_wR  out  5  registered: committed register index
- dbg_wD  out  32  registered: committed value
- commit_cnt  out  CNT_W  number of commits since reset

## Operation
- Writeback select: wsel 2'b00 → wb_ALU_C; 2'b01 → wb_DRAM_rdo; 2'b10 → wb_pc4; 2'b11 → wb_imm_ext. wb_wD is driven regardless of wb_rf_we.
- Commit condition: commit = wb_rf_we && (wb_wR != 0). On commit, regs[wb_wR] <= wb_wD at the rising edge.
- x0: reads return 0 always; never written; write attempts to x0 are not commits (no trace, no count).
- Read port n: if rRn == 0 → 0; else if commit && rRn == wb_wR → wb_wD (bypass); else regs[rRn]. Both ports bypass independently; both may hit the same register.
- Trace: each edge, dbg_we <= commit; dbg_wR/dbg_wD <= wb_wR/wb_wD when commit, else hold previous values.
- Counter: commit_cnt += 1 on each commit; wraps modulo 2^CNT_W with no flag.
- wb_rf_wsel, indices and data inputs are don't-care when wb_rf_we = 0.

## Timing
- Reset (async, immediate on rst assert): x1, x3–x31 = 0; x2 = X2_RESET; dbg_we = 0; dbg_wR = 0; dbg_wD = 0; commit_cnt = 0. rD1/rD2 reflect reset contents combinationally while rst is high. Commits presented while rst is high are discarded.
- First edge after rst deasserts performs a normal commit if presented.
- Write latency: value visible on rD via bypass in the same cycle it is presented; from the register array from the next cycle.
- Read latency: zero (combinational from rR*, wb_* and array state).
- Trace latency: dbg_* reflect the commit of the previous cycle; one entry per commit, no gaps or duplicates.
- Back-to-back commits to the same register: last writer wins; each counted and traced.
- Reset mid-stream: counter and trace clear immediately; no partial commit.

## Test plan
- Reset: X2_RESET=32'h0000_7FFC, pulse rst mid-cycle → rD for x2 = 32'h0000_7FFC, x5 = 0, commit_cnt = 0, dbg_we = 0.
- Source select: commit to x5 with wsel 00/01/10/11 and ALU_C=32'h11, DRAM=32'h22, pc4=32'h33, imm=32'h44 → x5 reads 32'h11, 32'h22, 32'h33, 32'h44 in successive cycles; commit_cnt = 4.
- Bypass: present commit x7=32'hDEAD_BEEF with rR1=rR2=7 same cycle → rD1=rD2=32'hDEAD_BEEF before the edge; next cycle (we=0) still 32'hDEAD_BEEF from array.
- x0: we=1, wR=0, wD=32'hFFFF_FFFF, rR1=0 → rD1=0, commit_cnt unchanged, dbg_we=0 next cycle.
- Trace/counter wrap: CNT_W=4, 17 consecutive commits to x1..x17 (mod) → commit_cnt = 1; dbg_wR/dbg_wD match each commit one cycle later.
- Reset mid-operation: assert rst while commit x9=32'h1234 presented → x9 = 0, commit_cnt = 0 after release.
